// File: rtl/quad_step_decoder_pkg.sv
// Purpose : shared Gray-code state constants, direction encoding and transition helpers
//           for the quadrature step decoder.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package quad_pkg;

  // Encoder state is {A,B}.
  typedef logic [1:0] qstate_t;

  localparam qstate_t ST_00 = 2'b00;
  localparam qstate_t ST_10 = 2'b10;
  localparam qstate_t ST_11 = 2'b11;
  localparam qstate_t ST_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Forward rotation: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic is_up(input qstate_t prev, input qstate_t cur);
    logic r;
    r = 1'b0;
    case (prev)
      ST_00:   r = (cur == ST_10);
      ST_10:   r = (cur == ST_11);
      ST_11:   r = (cur == ST_01);
      ST_01:   r = (cur == ST_00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Reverse rotation is a forward step with the endpoints swapped.
  function automatic logic is_down(input qstate_t prev, input qstate_t cur);
    return is_up(cur, prev);
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Purpose : encoder-side bundle of the quadrature step decoder (raw A/B in, step/dir/err out).
// Latency : n/a (wiring only).
// Backpressure: none; outputs are pulses/levels with no ready.
//   master : encoder/consumer side, drives enc_a/enc_b, observes step, up_down, err, err_cnt
//   slave  : decoder side, consumes enc_a/enc_b, drives the decoded outputs
interface quad_step_decoder_if #(
  parameter int ERR_W = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             step;
  logic             up_down;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (output enc_a, output enc_b,
                  input step, input up_down, input err, input err_cnt);
  modport slave  (input enc_a, input enc_b,
                  output step, output up_down, output err, output err_cnt);
endinterface

// File: rtl/quad_step_decoder_sync_filter.sv
// Purpose : 2-flop synchroniser plus stability filter for one raw encoder channel.
// Latency : a held raw change sampled at edge k reaches filt at edge k+1+FILT_CYCLES.
// Backpressure: none.
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous input channel
//   load       : when high, filt follows the synchronised value directly (settle window)
//   filt       : filtered channel value
module sync_filter #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic load,
  output logic filt
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      filt   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (load) begin
        filt <= sync_2;
        cnt  <= '0;
      end else if (sync_2 != filt) begin
        // Must disagree for FILT_CYCLES consecutive edges before the change is accepted.
        if (cnt == CNT_LAST) begin
          filt <= sync_2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // A return to agreement discards any pending change.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Purpose : quadrature A/B to step pulse + direction, with glitch filtering and illegal-jump counting.
// Latency : FILT_CYCLES+3 edges from raw edge sample to step/err pulse.
// Backpressure: none; step/err are single-cycle pulses the counter must take when presented.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of quad_step_decoder_if (enc_a/enc_b in; step, up_down, err, err_cnt out)
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_CYCLES = 4,
  parameter int X4          = 1,
  parameter int ERR_W       = 8
) (
  input logic                clk,
  input logic                reset,
  quad_step_decoder_if.slave bus
);

  localparam int SW = $clog2(FILT_CYCLES + 3);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(FILT_CYCLES + 1);

  logic [SW-1:0]    settle_cnt;
  logic             primed;
  logic             a_f;
  logic             b_f;
  qstate_t          prev;
  qstate_t          cur;
  logic             step_r;
  logic             up_down_r;
  logic             err_r;
  logic [ERR_W-1:0] err_cnt_r;

  sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_a),
    .load  (!primed),
    .filt  (a_f)
  );

  sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_b),
    .load  (!primed),
    .filt  (b_f)
  );

  assign cur = {a_f, b_f};

  // Settle window: filters track the synchronisers directly so an encoder resting at a
  // non-00 position after reset is adopted silently instead of looking like a jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
      primed     <= 1'b0;
    end else if (!primed) begin
      if (settle_cnt == SETTLE_LAST) begin
        primed <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= ST_00;
      step_r    <= 1'b0;
      err_r     <= 1'b0;
      up_down_r <= DIR_UP;
      err_cnt_r <= '0;
    end else begin
      prev   <= cur;
      step_r <= 1'b0;
      err_r  <= 1'b0;
      if (primed) begin
        if (is_up(prev, cur)) begin
          up_down_r <= DIR_UP;
          // In x1 mode only the arrival at 00 counts; direction still tracks every edge.
          step_r    <= (X4 != 0) || (cur == ST_00);
        end else if (is_down(prev, cur)) begin
          up_down_r <= DIR_DOWN;
          step_r    <= (X4 != 0) || (cur == ST_00);
        end else if ((prev ^ cur) == 2'b11) begin
          err_r <= 1'b1;
          if (err_cnt_r != '1) begin
            err_cnt_r <= err_cnt_r + 1'b1;
          end
        end
      end
    end
  end

  assign bus.step    = step_r;
  assign bus.up_down = up_down_r;
  assign bus.err     = err_r;
  assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Purpose : scoreboard bench for quad_step_decoder; two instances share stimulus
//           (x4 with 8-bit error count, x1 with 2-bit error count).
// Latency : expected pulse times come from a per-channel run-length model of the filter.
// Backpressure: n/a.
module tb_quad_step_decoder;

  localparam int FILT = 4;

  typedef struct {
    int t;
    bit is_err;
    bit dir;
    int cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q1[$];
  exp_t q2[$];
  bit   ra[$];
  bit   rb[$];
  bit   seg_a[$];
  bit   seg_b[$];
  int   seg_h[$];

  quad_step_decoder_if #(.ERR_W(8)) bus1();
  quad_step_decoder_if #(.ERR_W(2)) bus2();

  assign bus1.enc_a = enc_a;
  assign bus1.enc_b = enc_b;
  assign bus2.enc_a = enc_a;
  assign bus2.enc_b = enc_b;

  quad_step_decoder #(.FILT_CYCLES(FILT), .X4(1), .ERR_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  quad_step_decoder #(.FILT_CYCLES(FILT), .X4(0), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Position around the encoder wheel; forward motion is +1 mod 4.
  function automatic int wheel_pos(input bit a, input bit b);
    if (!a && !b) return 0;
    if (a && !b)  return 1;
    if (a && b)   return 2;
    return 3;
  endfunction

  // A run of a new value lasting at least FILT edges is accepted FILT+1 edges after it starts.
  task automatic filt_model(input bit r[$], input bit init, output bit f[$]);
    int n;
    int j;
    int s;
    bit v;
    bit curv;
    n = r.size();
    f.delete();
    for (int k = 0; k < n; k++) f.push_back(init);
    curv = init;
    j = 0;
    while (j < n) begin
      s = j;
      v = r[j];
      while (j < n && r[j] == v) j++;
      if (v != curv && (j - s) >= FILT) begin
        curv = v;
        for (int k = s + FILT + 1; k < n; k++) f[k] = v;
      end
    end
  endtask

  task automatic observe(input int id, input logic s, input logic e, input logic ud, input int cnt);
    exp_t x;
    int   sz;
    if (!(s || e)) return;
    sz = (id == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL d%0d_unexpected: step=%0b err=%0b at cycle %0d, no pulse expected", id, s, e, cyc);
      return;
    end
    if (id == 1) x = q1.pop_front();
    else         x = q2.pop_front();
    chk($sformatf("d%0d_time", id), cyc, x.t);
    chk($sformatf("d%0d_err", id), int'(e), int'(x.is_err));
    chk($sformatf("d%0d_step", id), int'(s), int'(!x.is_err));
    chk($sformatf("d%0d_dir", id), int'(ud), int'(x.dir));
    chk($sformatf("d%0d_errcnt", id), cnt, x.cnt);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      observe(1, bus1.step, bus1.err, bus1.up_down, int'(bus1.err_cnt));
      observe(2, bus2.step, bus2.err, bus2.up_down, int'(bus2.err_cnt));
    end
  end

  task automatic add_seg(input bit a, input bit b, input int h);
    seg_a.push_back(a);
    seg_b.push_back(b);
    seg_h.push_back(h);
  endtask

  task automatic clear_segs();
    seg_a.delete();
    seg_b.delete();
    seg_h.delete();
  endtask

  // Reset with inputs at (ia,ib), then play the segment list. m>0 cuts the run short
  // after m edges so the next scenario's reset lands mid-operation.
  task automatic run_scenario(input bit ia, input bit ib, input int m);
    int base;
    int n;
    int lim;
    int t;
    int c1;
    int c2;
    bit dir;
    bit la;
    bit lb;
    bit fa[$];
    bit fb[$];
    exp_t x;

    @(posedge clk); #1;
    reset = 1'b1;
    enc_a = ia;
    enc_b = ib;
    @(posedge clk); #1;
    chk("d1_rst_step", int'(bus1.step), 0);
    chk("d1_rst_err", int'(bus1.err), 0);
    chk("d1_rst_errcnt", int'(bus1.err_cnt), 0);
    chk("d1_rst_dir", int'(bus1.up_down), 1);
    chk("d2_rst_errcnt", int'(bus2.err_cnt), 0);
    chk("d2_rst_dir", int'(bus2.up_down), 1);
    reset = 1'b0;
    base  = cyc + 1;

    ra.delete();
    rb.delete();
    for (int k = 0; k < 12; k++) begin
      ra.push_back(ia);
      rb.push_back(ib);
    end
    la = ia;
    lb = ib;
    foreach (seg_h[i]) begin
      for (int k = 0; k < seg_h[i]; k++) begin
        ra.push_back(seg_a[i]);
        rb.push_back(seg_b[i]);
      end
      la = seg_a[i];
      lb = seg_b[i];
    end
    for (int k = 0; k < 30; k++) begin
      ra.push_back(la);
      rb.push_back(lb);
    end
    n = ra.size();

    filt_model(ra, ia, fa);
    filt_model(rb, ib, fb);
    dir = 1'b1;
    c1  = 0;
    c2  = 0;
    for (int j = 1; j < n; j++) begin
      if (fa[j] == fa[j-1] && fb[j] == fb[j-1]) continue;
      t = base + j + 1;
      if (fa[j] != fa[j-1] && fb[j] != fb[j-1]) begin
        if (c1 < 255) c1++;
        if (c2 < 3)   c2++;
        x = '{t: t, is_err: 1'b1, dir: dir, cnt: c1};
        q1.push_back(x);
        x.cnt = c2;
        q2.push_back(x);
      end else begin
        dir = (((wheel_pos(fa[j], fb[j]) - wheel_pos(fa[j-1], fb[j-1]) + 4) % 4) == 1);
        x = '{t: t, is_err: 1'b0, dir: dir, cnt: c1};
        q1.push_back(x);
        if (!fa[j] && !fb[j]) begin
          x.cnt = c2;
          q2.push_back(x);
        end
      end
    end

    lim = (m > 0 && m < n) ? m : n;
    for (int j = 0; j < lim; j++) begin
      enc_a = ra[j];
      enc_b = rb[j];
      @(posedge clk); #1;
    end

    if (lim < n) begin
      @(negedge clk); #1;
      while (q1.size() > 0 && q1[q1.size()-1].t > cyc) void'(q1.pop_back());
      while (q2.size() > 0 && q2[q2.size()-1].t > cyc) void'(q2.pop_back());
    end else begin
      repeat (2) @(negedge clk);
      #1;
    end
    chk("d1_missing_pulses", q1.size(), 0);
    chk("d2_missing_pulses", q2.size(), 0);
    q1.delete();
    q2.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;

    // Forward rotation.
    clear_segs();
    add_seg(1, 0, 12); add_seg(1, 1, 12); add_seg(0, 1, 12); add_seg(0, 0, 12);
    run_scenario(0, 0, 0);

    // Reverse rotation.
    clear_segs();
    add_seg(0, 1, 12); add_seg(1, 1, 12); add_seg(1, 0, 12); add_seg(0, 0, 12);
    run_scenario(0, 0, 0);

    // Short glitch on A is rejected, then a held edge is accepted.
    clear_segs();
    add_seg(1, 0, 3); add_seg(0, 0, 8); add_seg(1, 0, 12);
    run_scenario(0, 0, 0);

    // Illegal double-bit jumps; second instance saturates its 2-bit counter.
    clear_segs();
    add_seg(1, 1, 12); add_seg(0, 0, 12); add_seg(1, 1, 12); add_seg(0, 0, 12); add_seg(1, 1, 12);
    run_scenario(0, 0, 0);

    // Resting at 11 across reset, then one forward edge.
    clear_segs();
    add_seg(0, 1, 12);
    run_scenario(1, 1, 0);

    // Random motion with glitches.
    repeat (4) begin
      clear_segs();
      repeat ($urandom_range(20, 40)) add_seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
      run_scenario(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Random motion cut short by a reset mid-operation, then a clean scenario.
    repeat (2) begin
      clear_segs();
      repeat (30) add_seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(2, 12));
      run_scenario(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(40, 150));
    end
    clear_segs();
    add_seg(1, 0, 12); add_seg(1, 1, 12); add_seg(0, 1, 12); add_seg(0, 0, 12);
    run_scenario(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage for the N-bit up/down counter.
- Converts two raw asynchronous quadrature encoder channels (A/B) into a one-cycle step pulse and a direction level.
- The downstream counter advances once per step pulse, in the direction given by up_down.
- Provides input synchronisation, per-channel glitch filtering, Gray-code decoding and illegal-transition error reporting.

Parameters:
- FILT_CYCLES, 4, consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (legal range 1..255).
- X4, 1, 1 = one step per valid transition (4 per encoder cycle); 0 = one step per cycle, only on transitions into state 00.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; all state is cleared on a clk edge with reset=1.
- enc_a  input  1  raw channel A, asynchronous to clk.
- enc_b  input  1  raw channel B, asynchronous to clk.
- step  output  1  one-cycle pulse, one per decoded step.
- up_down  output  1  direction of the last valid step; 1 = up, 0 = down.
- err  output  1  one-cycle pulse on an illegal transition.
- err_cnt  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Reset values:
  - step=0, err=0, err_cnt=0, up_down=1.
  - Synchroniser and filtered values = 0, filter counters = 0.
  - settle counter = 0, primed = 0.
- Synchroniser: two flops per channel, giving a_s/b_s.
- Filter, per channel:
  - When a_s != a_f, the counter increments; otherwise it clears to 0.
  - When the counter reaches FILT_CYCLES-1 and a_s still differs, a_f <= a_s on the next edge and the counter clears.
  - Any return to equality before that point discards the pending change.
- Settle window after reset release:
  - Lasts FILT_CYCLES+2 cycles, with primed=0.
  - During the window, a_f/b_f load a_s/b_s directly every cycle, and step/err stay 0.
  - At the end of the window, primed=1.
  - This prevents a false error when the encoder rests at a non-00 state.
- Decoder: registered; compares prev={a_f,b_f} of the previous cycle with the current {a_f,b_f}. State is {A,B}.
  - Up sequence: 00->10->11->01->00. Down sequence: the reverse.
  - No change: no output.
  - Valid up: step=1 (subject to X4), up_down<=1.
  - Valid down: step=1 (subject to X4), up_down<=0.
  - Both bits changed in the same cycle: err=1, err_cnt+1 saturating at all-ones, no step, up_down unchanged.
  - prev is updated in every case.
  - X4=0: a valid transition whose destination is not 00 updates up_down but asserts no step.
- Latency:
  - Raw edge sampled at clk edge k, then held stable.
  - a_f updates at edge k+1+FILT_CYCLES.
  - step is high in the cycle following edge k+2+FILT_CYCLES, i.e. FILT_CYCLES+3 edges (7 at the default).
- step and up_down come from the same register stage, so up_down is valid in the same cycle as step.
- Reset mid-operation: all pending filter changes are dropped, outputs return to reset values, and the settle window restarts.
- Both channels' filters qualifying on the same edge counts as simultaneous, i.e. an error.

Decomposition:
- Package quad_pkg:
  - 2-bit state constants ST_00, ST_10, ST_11, ST_01.
  - DIR_UP=1, DIR_DOWN=0.
  - Function is_up(prev,cur) and function is_down(prev,cur).
- Sub-module sync_filter (2-flop synchroniser + stability filter, parameter FILT_CYCLES):
  - Instantiated once per channel.
  - Exposes the filtered bit.
  - Has a load-direct input used during the settle window.

Test Plan:
- FILT_CYCLES=4, X4=1, reset then inputs at 00; drive 00->10->11->01->00, each held 12 cycles -> 4 step pulses, each 7 edges after its input change; up_down=1; err never asserted.
- Same, reversed sequence 00->01->11->10->00 -> 4 step pulses; up_down=0 from the first step onward.
- From 00, pulse enc_a high for 3 cycles, then low -> no step, a_f stays 0. Then hold high for 4+ cycles -> one step, up_down=1.
- From 00, change both inputs to 11 on the same cycle -> err pulse, err_cnt=1, no step, up_down unchanged. With ERR_W=2, force 5 illegal jumps -> err_cnt=3 (saturated).
- Hold inputs at 11, assert reset for 1 cycle, wait for the settle window -> no err, no step. Then 11->01 -> one step, up_down=1.
- X4=0, full up cycle from 00 -> exactly one step, at the 01->00 transition, up_down=1.
